float_mul_pipeline_tagged: RTL and testbench
============================================

// Module: float_mul_pipeline_tagged
// PURPOSE
//  Fully pipelined IEEE-754 single-precision multiplier: one new operation accepted per cycle, results returned in order.
//  Each result carries a caller tag. Output side has valid/ready backpressure that stalls the whole pipeline.
//  Sits between the GPU core float issue logic and register writeback.
//  Successor to the single-request float_mul_pipeline.
// PARAMETERS
//  STAGES     3   total latency in cycles, range 3..8; stages beyond 3 are plain delay registers after pack
//  TAG_WIDTH  4   width of the opaque tag carried alongside each operation
// PORTS
//  clk       in   1                   clock, all logic on posedge
//  rst       in   1                   asynchronous reset, active-low
//  req       in   1                   operation valid
//  in_ready  out  1                   operation accepted when req && in_ready
//  a         in   32                  operand A, float_width = 32
//  b         in   32                  operand B
//  tag_in    in   TAG_WIDTH           tag for this operation
//  ack       out  1                   result valid
//  out_ready in   1                   consumer accepts result when ack && out_ready
//  out       out  32                  product
//  tag_out   out  TAG_WIDTH           tag of the current result
//  inflight  out  $clog2(STAGES+1)    number of valid entries in the pipeline
// BEHAVIOUR
//  Reset (rst low, async):
//   - all stage valid bits cleared; ack=0, out=0, tag_out=0, inflight=0; in-flight ops are discarded.
//   - in_ready=1 on the first cycle after reset deasserts.
//  Stall and handshake:
//   - stall = ack && !out_ready.
//   - in_ready = !stall (combinational). While stalled every stage register holds its value.
//   - When not stalled, all stages advance together and bubbles propagate.
//   - Once ack rises, out and tag_out stay stable until the beat where out_ready is high.
//   - Latency is exactly STAGES cycles from accept to ack when no stall occurs. Throughput is 1 op/cycle.
//   - Results come out in issue order.
//  inflight counter:
//   - +1 on accept, -1 on output handshake, unchanged when both happen in the same cycle.
//   - Never exceeds STAGES.
//  S1, unpack:
//   - sign = a[31]^b[31]; exp_sum = ea+eb-127, 10-bit signed.
//   - flags: zero (exp==0; denormals are flushed to zero), inf, nan.
//  S2, multiply: 24x24 -> 48-bit mantissa product, implicit leading ones restored.
//  S3, normalise and pack:
//   - if product bit 47 is set: shift right 1 and exp+1.
//   - rounding per CONFIGURATION.
//   - rounding carry-out renormalises: exp+1, mantissa 0.
//  Specials, in priority order:
//   - NaN input, or inf*zero -> 0x7FC00000.
//   - inf input -> sign|0x7F800000.
//   - zero input -> sign|0 (signed zero).
//   - exp>=255 -> sign|0x7F800000 (overflow to inf).
//   - exp<=0 -> sign|0 (underflow flushed).
//  Simultaneous accept and output on the same cycle is legal and counted as described above.
//  Deasserting req while stalled has no effect on the stage registers.
// CONFIGURATION
//  FLOAT_MUL_ROUND_NEAREST_EN defined:
//   - round to nearest, ties to even, using guard bit and sticky OR of the discarded product bits.
//  FLOAT_MUL_ROUND_NEAREST_EN undefined:
//   - truncate (round toward zero), matching float_mul_pipeline.
//  Latency and the interface are identical in both builds.
// TESTING
//  - a=0x3F99999A (1.2), b=0x40600000 (3.5), tag 5, out_ready=1
//      -> ack exactly STAGES cycles later, out=0x40866666, tag_out=5.
//  - a=0x3FC00000, b=0x3F800001
//      -> out=0x3FC00001 without the macro; 0x3FC00002 with FLOAT_MUL_ROUND_NEAREST_EN.
//  - specials:
//      0x80000000*0x3F800000 -> 0x80000000
//      0xC0000000*0x40400000 -> 0xC0C00000
//      0x7F000000*0x40000000 -> 0x7F800000
//      0x7F800000*0x00000000 -> 0x7FC00000
//  - back-to-back issue of tags 0..3 (1.0*1.0, 2.0*2.0, 2.0*2.3, 8.0*4.0) with out_ready=0:
//      - in_ready drops once the first result reaches ack; inflight reaches 4 with STAGES>=4.
//      - then out_ready=1 -> 0x3F800000, 0x40800000, 0x40933333, 0x42000000 returned in tag order 0..3, none lost.
//  - drive rst low while 2 ops are in flight:
//      -> ack=0 and inflight=0 immediately; no stale result appears after rst is released.
//  - continuous req with out_ready toggling every cycle for 100 ops
//      -> every result matches the reference model, in order, with no duplicates.

Source files
------------

// File: rtl/float_mul_pipeline_tagged_if.sv
// Issue/result bundle for float_mul_pipeline_tagged: operands and tag in,
// tagged product out, valid/ready on both sides plus the occupancy count.
interface float_mul_pipeline_tagged_if #(
  parameter int STAGES    = 3,
  parameter int TAG_WIDTH = 4
);
  localparam int CNT_W = $clog2(STAGES + 1);

  logic                 req;
  logic                 in_ready;
  logic [31:0]          a;
  logic [31:0]          b;
  logic [TAG_WIDTH-1:0] tag_in;
  logic                 ack;
  logic                 out_ready;
  logic [31:0]          out;
  logic [TAG_WIDTH-1:0] tag_out;
  logic [CNT_W-1:0]     inflight;

  modport master (
    output req, a, b, tag_in, out_ready,
    input  in_ready, ack, out, tag_out, inflight
  );

  modport slave (
    input  req, a, b, tag_in, out_ready,
    output in_ready, ack, out, tag_out, inflight
  );
endinterface

// File: rtl/float_mul_pipeline_tagged.sv
// Fully pipelined single-precision multiplier with caller tags and a whole-pipe output stall.
// Define FLOAT_MUL_ROUND_NEAREST_EN for round-to-nearest-even; the default build truncates.
module float_mul_pipeline_tagged #(
  parameter int STAGES    = 3,
  parameter int TAG_WIDTH = 4
) (
  input logic                        clk,
  input logic                        rst,
  float_mul_pipeline_tagged_if.slave io
);
  localparam int CNT_W = $clog2(STAGES + 1);
  localparam int TAIL  = STAGES - 2;  // pack stage plus trailing delay registers

  typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} special_e;

  typedef struct packed {
    logic                 sign;
    logic signed [9:0]    exp;
    special_e             spec;
    logic [23:0]          ma;
    logic [23:0]          mb;
    logic [TAG_WIDTH-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic                 sign;
    logic signed [9:0]    exp;
    special_e             spec;
    logic [47:0]          prod;
    logic [TAG_WIDTH-1:0] tag;
  } s2_t;

  typedef struct packed {
    logic [31:0]          data;
    logic [TAG_WIDTH-1:0] tag;
  } res_t;

  logic              stall, accept, retire;
  logic [STAGES-1:0] vld_q, vld_d;
  s1_t               s1_q, s1_d;
  s2_t               s2_q, s2_d;
  res_t              res_q [TAIL];
  res_t              res_d [TAIL];
  res_t              pack_res;
  logic [CNT_W-1:0]  inflight_q, inflight_d;

  assign io.ack      = vld_q[STAGES-1];
  assign stall       = io.ack & ~io.out_ready;
  assign io.in_ready = ~stall;
  assign accept      = io.req & ~stall;
  assign retire      = io.ack & io.out_ready;
  assign io.out      = res_q[TAIL-1].data;
  assign io.tag_out  = res_q[TAIL-1].tag;
  assign io.inflight = inflight_q;

  // S1: unpack and classify. Exponent field 0 means zero (denormals flushed).
  logic [7:0] ea, eb;
  logic       za, zb, ia, ib, na, nb;

  assign ea = io.a[30:23];
  assign eb = io.b[30:23];
  assign za = (ea == 8'h00);
  assign zb = (eb == 8'h00);
  assign ia = (ea == 8'hFF) && (io.a[22:0] == 23'd0);
  assign ib = (eb == 8'hFF) && (io.b[22:0] == 23'd0);
  assign na = (ea == 8'hFF) && (io.a[22:0] != 23'd0);
  assign nb = (eb == 8'hFF) && (io.b[22:0] != 23'd0);

  always_comb begin
    // NOTE: each stage defaults to its held value first, so no path through the block can infer a latch.
    s1_d = s1_q;
    if (!stall) begin
      s1_d.sign = io.a[31] ^ io.b[31];
      s1_d.exp  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
      if (na || nb || (ia && zb) || (ib && za)) s1_d.spec = SP_NAN;
      else if (ia || ib)                        s1_d.spec = SP_INF;
      else if (za || zb)                        s1_d.spec = SP_ZERO;
      else                                      s1_d.spec = SP_NONE;
      s1_d.ma  = {1'b1, io.a[22:0]};
      s1_d.mb  = {1'b1, io.b[22:0]};
      s1_d.tag = io.tag_in;
    end
  end

  // S2: full 48-bit mantissa product.
  always_comb begin
    s2_d = s2_q;
    if (!stall) begin
      s2_d.sign = s1_q.sign;
      s2_d.exp  = s1_q.exp;
      s2_d.spec = s1_q.spec;
      s2_d.prod = {24'd0, s1_q.ma} * {24'd0, s1_q.mb};
      s2_d.tag  = s1_q.tag;
    end
  end

  // S3: normalise, round, pack.
  logic [22:0]       mant, mant_f;
  logic              guard, sticky, round_up;
  logic [23:0]       mant_r;
  logic signed [9:0] exp_n, exp_f;

  always_comb begin
    if (s2_q.prod[47]) begin
      mant   = s2_q.prod[46:24];
      guard  = s2_q.prod[23];
      sticky = |s2_q.prod[22:0];
      exp_n  = s2_q.exp + 10'sd1;
    end else begin
      mant   = s2_q.prod[45:23];
      guard  = s2_q.prod[22];
      sticky = |s2_q.prod[21:0];
      exp_n  = s2_q.exp;
    end
  end

`ifdef FLOAT_MUL_ROUND_NEAREST_EN
  assign round_up = guard & (sticky | mant[0]);
`else
  // Truncation ignores the discarded bits.
  logic round_bits_unused;
  assign round_bits_unused = guard ^ sticky;
  assign round_up          = 1'b0;
`endif

  assign mant_r = {1'b0, mant} + {23'd0, round_up};

  always_comb begin
    exp_f  = exp_n;
    mant_f = mant_r[22:0];
    if (mant_r[23]) begin
      exp_f  = exp_n + 10'sd1;
      mant_f = '0;
    end
    pack_res.tag  = s2_q.tag;
    pack_res.data = '0;
    unique case (s2_q.spec)
      SP_NAN:  pack_res.data = 32'h7FC0_0000;
      SP_INF:  pack_res.data = {s2_q.sign, 8'hFF, 23'd0};
      SP_ZERO: pack_res.data = {s2_q.sign, 31'd0};
      default: begin
        if (exp_f >= 10'sd255)   pack_res.data = {s2_q.sign, 8'hFF, 23'd0};
        else if (exp_f <= 10'sd0) pack_res.data = {s2_q.sign, 31'd0};
        else                     pack_res.data = {s2_q.sign, exp_f[7:0], mant_f};
      end
    endcase
  end

  // Tail, valid chain and occupancy.
  always_comb begin
    vld_d    = stall ? vld_q : {vld_q[STAGES-2:0], accept};
    res_d[0] = stall ? res_q[0] : pack_res;
    for (int i = 1; i < TAIL; i++) res_d[i] = stall ? res_q[i] : res_q[i-1];
    inflight_d = inflight_q;
    if (accept && !retire)      inflight_d = inflight_q + CNT_W'(1);
    else if (!accept && retire) inflight_d = inflight_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: data registers are cleared along with the valids because out and tag_out must read 0 in reset.
      vld_q      <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      inflight_q <= '0;
      for (int i = 0; i < TAIL; i++) res_q[i] <= '0;
    end else begin
      // NOTE: non-blocking updates let every stage sample its upstream neighbour's pre-edge value.
      vld_q      <= vld_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      inflight_q <= inflight_d;
      for (int i = 0; i < TAIL; i++) res_q[i] <= res_d[i];
    end
  end
endmodule

// File: tb/tb_float_mul_pipeline_tagged.sv
// Randomised and directed bench for float_mul_pipeline_tagged against an arithmetic reference model.
module tb_float_mul_pipeline_tagged;
  localparam int STAGES = 3;
  localparam int TW     = 4;
  localparam int CW     = $clog2(STAGES + 1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  float_mul_pipeline_tagged_if #(.STAGES(STAGES), .TAG_WIDTH(TW)) bus ();

  float_mul_pipeline_tagged #(.STAGES(STAGES), .TAG_WIDTH(TW)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  typedef struct packed {
    logic [31:0]   d;
    logic [TW-1:0] t;
  } beat_t;

  beat_t exp_q[$];
  beat_t obs_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    hold_viol  = 0;
  int    ready_viol = 0;
  int    count_viol = 0;
  int    model_cnt  = 0;
  logic  prev_stall = 1'b0;
  beat_t prev_beat;

  // Reference: exact integer product, rounding decided from the remainder.
  function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    int     ex, ey, e, sh;
    logic   s, zx, zy, ix, iy, nx, ny;
    longint p, m, rem, half;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    s  = x[31] ^ y[31];
    zx = (ex == 0);
    zy = (ey == 0);
    ix = (ex == 255) && (x[22:0] == 23'd0);
    iy = (ey == 255) && (y[22:0] == 23'd0);
    nx = (ex == 255) && (x[22:0] != 23'd0);
    ny = (ey == 255) && (y[22:0] != 23'd0);
    if (nx || ny || (ix && zy) || (iy && zx)) return 32'h7FC0_0000;
    if (ix || iy) return {s, 8'hFF, 23'd0};
    if (zx || zy) return {s, 31'd0};
    p    = longint'({1'b1, x[22:0]}) * longint'({1'b1, y[22:0]});
    sh   = (p >= (longint'(1) << 47)) ? 24 : 23;
    m    = p >> sh;
    rem  = p - (m << sh);
    half = longint'(1) << (sh - 1);
    e    = ex + ey - 127 + (sh - 23);
`ifdef FLOAT_MUL_ROUND_NEAREST_EN
    if (rem > half || (rem == half && (m % 2) == 1)) m = m + 1;
`endif
    if (m == (longint'(1) << 24)) begin
      m = m >> 1;
      e = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0)   return {s, 31'd0};
    return {s, e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    int          r;
    logic [7:0]  e;
    logic [22:0] f;
    r = $urandom_range(0, 15);
    f = 23'($urandom);
    case (r)
      0: e = 8'h00;
      1: begin
        e = 8'hFF;
        if ($urandom_range(0, 1) == 1) f = '0;
      end
      2: e = 8'($urandom_range(200, 254));
      3: e = 8'($urandom_range(1, 60));
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {1'($urandom), e, f};
  endfunction

  // Passive monitor: records output beats and tracks protocol invariants.
  always @(negedge clk) begin
    if (!rst) begin
      model_cnt  = 0;
      prev_stall = 1'b0;
    end else begin
      if (bus.inflight !== CW'(model_cnt) || model_cnt > STAGES) count_viol++;
      if (bus.in_ready !== !(bus.ack && !bus.out_ready)) ready_viol++;
      if (prev_stall && (bus.ack !== 1'b1 || {bus.out, bus.tag_out} !== prev_beat)) hold_viol++;
      prev_stall = bus.ack && !bus.out_ready;
      prev_beat  = {bus.out, bus.tag_out};
      if (bus.ack && bus.out_ready) obs_q.push_back({bus.out, bus.tag_out});
      model_cnt += ((bus.req && bus.in_ready) ? 1 : 0) - ((bus.ack && bus.out_ready) ? 1 : 0);
    end
  end

  // Present one operation at posedge+1 and hold it until accepted.
  task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic [TW-1:0] it);
    bit acc;
    int budget;
    acc    = 1'b0;
    budget = 200;
    bus.req    = 1'b1;
    bus.a      = ia;
    bus.b      = ib;
    bus.tag_in = it;
    while (!acc && budget > 0) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      budget--;
    end
    if (acc) exp_q.push_back({ref_mul(ia, ib), it});
    else begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout: tag %0d never accepted, required acceptance within 200 cycles", it);
    end
  endtask

  task automatic drain(input int n);
    int budget;
    budget = 0;
    while (obs_q.size() < n && budget < 500) begin
      @(posedge clk);
      #1;
      budget++;
    end
    if (obs_q.size() < n) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d results, required %0d", obs_q.size(), n);
    end
  endtask

  task automatic test_reset();
    bus.req = 1'b0; bus.a = '0; bus.b = '0; bus.tag_in = '0; bus.out_ready = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", bus.ack); end
    n_checks++; if (bus.inflight !== '0) begin n_fail++; $display("FAIL reset_inflight: got %0d expected 0", bus.inflight); end
    n_checks++; if (bus.out !== 32'h0) begin n_fail++; $display("FAIL reset_out: got %h expected 00000000", bus.out); end
    n_checks++; if (bus.tag_out !== '0) begin n_fail++; $display("FAIL reset_tag: got %h expected 0", bus.tag_out); end
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_latency();
    logic [31:0]   exp_d, got_d;
    logic [TW-1:0] got_t;
    int            lat;
`ifdef FLOAT_MUL_ROUND_NEAREST_EN
    exp_d = 32'h4086_6667;
`else
    exp_d = 32'h4086_6666;
`endif
    lat = -1; got_d = '0; got_t = '0;
    bus.out_ready = 1'b1;
    bus.req = 1'b1; bus.a = 32'h3F99_999A; bus.b = 32'h4060_0000; bus.tag_in = TW'(5);
    @(posedge clk);
    #1 bus.req = 1'b0;
    for (int c = 1; c <= STAGES + 4; c++) begin
      @(negedge clk);
      if (bus.ack === 1'b1 && lat < 0) begin
        lat = c; got_d = bus.out; got_t = bus.tag_out;
      end
    end
    @(posedge clk);
    #1;
    obs_q.delete();
    exp_q.delete();
    n_checks++; if (lat != STAGES) begin n_fail++; $display("FAIL latency: got %0d expected %0d", lat, STAGES); end
    n_checks++; if (got_d !== exp_d) begin n_fail++; $display("FAIL latency_data: got %h expected %h", got_d, exp_d); end
    n_checks++; if (got_t !== TW'(5)) begin n_fail++; $display("FAIL latency_tag: got %0d expected 5", got_t); end
  endtask

  task automatic test_specials();
    logic [31:0] va [8];
    logic [31:0] vb [8];
    logic [31:0] vexp [8];
    beat_t       o;
    va   = '{32'h3FC00000, 32'h80000000, 32'hC0000000, 32'h7F000000,
             32'h7F800000, 32'h00800000, 32'h7FC00001, 32'hFF800000};
    vb   = '{32'h3F800001, 32'h3F800000, 32'h40400000, 32'h40000000,
             32'h00000000, 32'h00800000, 32'h3F800000, 32'h40000000};
    vexp = '{32'h3FC00001, 32'h80000000, 32'hC0C00000, 32'h7F800000,
             32'h7FC00000, 32'h00000000, 32'h7FC00000, 32'hFF800000};
`ifdef FLOAT_MUL_ROUND_NEAREST_EN
    vexp[0] = 32'h3FC00002;
`endif
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) issue(va[i], vb[i], TW'(i));
    bus.req = 1'b0;
    drain(8);
    for (int i = 0; i < 8 && obs_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      n_checks++;
      if (o.d !== vexp[i] || o.t !== TW'(i)) begin
        n_fail++;
        $display("FAIL special_%0d: got %h tag %0d expected %h tag %0d", i, o.d, o.t, vexp[i], i);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic [31:0] vexp [4];
    bit          saw_drop;
    int          max_inf, want_inf;
    beat_t       o;
    va   = '{32'h3F800000, 32'h40000000, 32'h40000000, 32'h41000000};
    vb   = '{32'h3F800000, 32'h40000000, 32'h40133333, 32'h40800000};
    vexp = '{32'h3F800000, 32'h40800000, 32'h40933333, 32'h42000000};
    saw_drop = 1'b0;
    max_inf  = 0;
    want_inf = (STAGES < 4) ? STAGES : 4;
    bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) issue(va[i], vb[i], TW'(i));
        bus.req = 1'b0;
      end
      begin
        for (int c = 0; c < STAGES + 6; c++) begin
          @(negedge clk);
          if (bus.ack === 1'b1 && bus.in_ready === 1'b0) saw_drop = 1'b1;
          if (int'(bus.inflight) > max_inf) max_inf = int'(bus.inflight);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    n_checks++; if (!saw_drop) begin n_fail++; $display("FAIL b2b_in_ready_drop: got no drop expected in_ready=0 while stalled"); end
    n_checks++; if (max_inf != want_inf) begin n_fail++; $display("FAIL b2b_inflight_max: got %0d expected %0d", max_inf, want_inf); end
    drain(4);
    for (int i = 0; i < 4 && obs_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      n_checks++;
      if (o.d !== vexp[i] || o.t !== TW'(i)) begin
        n_fail++;
        $display("FAIL b2b_%0d: got %h tag %0d expected %h tag %0d", i, o.d, o.t, vexp[i], i);
      end
    end
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL b2b_extra: got %0d extra results expected 0", obs_q.size()); end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_inflight();
    bus.out_ready = 1'b0;
    issue(32'h3F800000, 32'h40000000, TW'(9));
    issue(32'h40400000, 32'h40000000, TW'(10));
    bus.req = 1'b0;
    repeat (STAGES - 2) @(posedge clk);
    #1;
    n_checks++; if (bus.ack !== 1'b1) begin n_fail++; $display("FAIL rst_pre_ack: got %b expected 1", bus.ack); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if (bus.ack !== 1'b0) begin n_fail++; $display("FAIL rst_async_ack: got %b expected 0", bus.ack); end
    n_checks++; if (bus.inflight !== '0) begin n_fail++; $display("FAIL rst_async_inflight: got %0d expected 0", bus.inflight); end
    @(posedge clk);
    #1 rst = 1'b1;
    bus.out_ready = 1'b1;
    exp_q.delete();
    obs_q.delete();
    repeat (2 * STAGES + 4) @(posedge clk);
    #1;
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL rst_stale: got %0d results expected 0", obs_q.size()); end
    n_checks++; if (bus.inflight !== '0) begin n_fail++; $display("FAIL rst_post_inflight: got %0d expected 0", bus.inflight); end
    obs_q.delete();
  endtask

  task automatic test_random();
    bit    done;
    beat_t o, e;
    int    n_exp;
    done = 1'b0;
    bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 100; i++) issue(rand_op(), rand_op(), i[TW-1:0]);
        bus.req = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 bus.out_ready = ~bus.out_ready;
        end
      end
    join
    bus.out_ready = 1'b1;
    drain(100);
    n_exp = exp_q.size();
    for (int i = 0; i < n_exp; i++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL random_%0d: got %h tag %0d expected %h tag %0d", i, o.d, o.t, e.d, e.t);
      end
    end
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL random_extra: got %0d extra results expected 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_protocol();
    n_checks++; if (hold_viol != 0) begin n_fail++; $display("FAIL stall_hold: got %0d violations expected 0", hold_viol); end
    n_checks++; if (ready_viol != 0) begin n_fail++; $display("FAIL in_ready_rule: got %0d violations expected 0", ready_viol); end
    n_checks++; if (count_viol != 0) begin n_fail++; $display("FAIL inflight_count: got %0d violations expected 0", count_viol); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_specials();
    test_back_to_back();
    test_reset_inflight();
    test_random();
    test_protocol();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
